// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
// Default geometry, the count/pointer width function and the wrapping pointer increment.
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    // Smallest r with 2**r >= n; used for both pointer and count widths.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Depth need not be a power of two, so wrap by compare rather than overflow.
    function automatic int ptr_next(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer side of the synchronous FIFO: request, data and status signals.
// master drives requests; slave is the FIFO itself.
interface fifo_sync_param_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CW = clog2(DEPTH + 1);

    logic             wr;
    logic [WIDTH-1:0] data_in;
    logic             rd;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;
    logic [CW-1:0]    fifo_cnt;

    modport master (
        output wr, data_in, rd,
        input  data_out, full, empty, almost_full, almost_empty,
               overflow, underflow, fifo_cnt
    );

    modport slave (
        input  wr, data_in, rd,
        output data_out, full, empty, almost_full, almost_empty,
               overflow, underflow, fifo_cnt
    );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port DEPTH x WIDTH storage: synchronous write, registered read with enable.
// The array is never reset; only the read register clears so data_out starts at zero.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // Same-address read+write returns the old word, which is what a full FIFO needs.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata_q <= '0;
        else      rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: pointers, occupancy count, threshold flags and
// one-cycle overflow/underflow pulses around a dual-port storage array.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    fifo_sync_param_if.slave bus
);

    localparam int CW = clog2(DEPTH + 1);
    localparam int PW = clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          rd_ok, wr_ok;
    logic          is_full, is_empty;

    assign is_full  = (cnt_q == CW'(DEPTH));
    assign is_empty = (cnt_q == '0);

    // A write into a full FIFO is only legal when a read frees the slot that same cycle.
    always_comb begin
        rd_ok    = bus.rd & ~is_empty;
        wr_ok    = bus.wr & (~is_full | rd_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_ok) wr_ptr_d = PW'(ptr_next(int'(wr_ptr_q), DEPTH));
        if (rd_ok) rd_ptr_d = PW'(ptr_next(int'(rd_ptr_q), DEPTH));
        if (wr_ok && !rd_ok)      cnt_d = cnt_q + 1'b1;
        else if (rd_ok && !wr_ok) cnt_d = cnt_q - 1'b1;
        ovf_d = bus.wr & ~wr_ok;
        udf_d = bus.rd & ~rd_ok;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wr_ptr_q),
        .wdata (bus.data_in),
        .re    (rd_ok),
        .raddr (rd_ptr_q),
        .rdata (bus.data_out)
    );

    assign bus.fifo_cnt     = cnt_q;
    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = (cnt_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (cnt_q <= CW'(AE_LEVEL));
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench for fifo_sync_param (8x8, AF=6, AE=2): the driver predicts each
// cycle's outcome into a queue and a monitor compares after every rising edge.
module tb_fifo_sync_param;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 2;

    typedef struct {
        int       cnt;
        bit       ovf;
        bit       udf;
        bit [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fifo_sync_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

    fifo_sync_param #(
        .WIDTH    (W),
        .DEPTH    (D),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t     sb_q[$];
    bit [7:0] model[$];
    bit [7:0] last_out = 8'h00;
    int       n_chk    = 0;
    int       n_fail   = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Status outputs are compared against the bench's own view of occupancy.
    function automatic void chk_status(string tag, int cnt, bit ovf, bit udf);
        chk({tag, " fifo_cnt"},     32'(bus.fifo_cnt),     32'(cnt));
        chk({tag, " full"},         32'(bus.full),         32'(cnt == D));
        chk({tag, " empty"},        32'(bus.empty),        32'(cnt == 0));
        chk({tag, " almost_full"},  32'(bus.almost_full),  32'(cnt >= AF));
        chk({tag, " almost_empty"}, 32'(bus.almost_empty), 32'(cnt <= AE));
        chk({tag, " overflow"},     32'(bus.overflow),     32'(ovf));
        chk({tag, " underflow"},    32'(bus.underflow),    32'(udf));
    endfunction

    // Drive one cycle of requests and push the predicted post-edge state.
    task automatic cycle(input bit w, input bit [7:0] d, input bit r);
        exp_t e;
        bit   rok, wok;
        @(negedge clk);
        bus.wr      = w;
        bus.data_in = d;
        bus.rd      = r;
        rok = r && (model.size() > 0);
        wok = w && ((model.size() < D) || rok);
        e.data = last_out;
        if (rok) e.data = model.pop_front();
        if (wok) model.push_back(d);
        last_out = e.data;
        e.cnt = model.size();
        e.ovf = w && !wok;
        e.udf = r && !rok;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        cycle(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
        #2;
        chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("data_out", 32'(bus.data_out), 32'(e.data));
                chk_status("cycle", e.cnt, e.ovf, e.udf);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        bus.data_in = '0;
        #12;
        chk("reset data_out", 32'(bus.data_out), 32'd0);
        chk_status("reset", 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Basic write four, read four.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 4; i++)  cycle(1'b0, 8'h00, 1'b1);
        drain();

        // Read while empty: single underflow pulse, output held.
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        drain();

        // Fill past capacity: ninth write rejected.
        for (int i = 0; i < 9; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0);
        // Full with read+write: count stays at depth, 0xAA lands behind seven survivors.
        cycle(1'b1, 8'hAA, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
        // Empty with read+write: write accepted, read rejected, no fall-through.
        cycle(1'b1, 8'hC3, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        drain();

        // Interleaved traffic across pointer wrap, occupancy kept within 1..5.
        cycle(1'b1, 8'h2F, 1'b0);
        for (int i = 0; i < 20; i++) begin
            bit w, r;
            w = (model.size() < 5) && ((i % 4) != 3);
            r = (model.size() > 1) && ((i % 3) != 0);
            cycle(w, 8'h30 + 8'(i), r);
        end
        while (model.size() > 0) cycle(1'b0, 8'h00, 1'b1);
        drain();

        // Asynchronous reset mid-stream with five entries held.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h70 + 8'(i), 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'h7F, 1'b0);
        drain();
        chk("pre-reset fifo_cnt", 32'(bus.fifo_cnt), 32'd5);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async reset data_out", 32'(bus.data_out), 32'd0);
        chk_status("async reset", 0, 1'b0, 1'b0);
        model.delete();
        last_out = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 8'h55, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
